// File: rtl/term_iq_pkg.sv
// Shared types and helpers for the terminate issue queue.
// Source slot indices, entry layout and index-width helpers.
package term_iq_pkg;

    localparam int SRC_LO    = 0;
    localparam int SRC_HI    = 1;
    localparam int SRC_FLAGS = 2;

    // Payload and operand state of one queue slot; tags/ROB are kept
    // alongside since their widths are parameters of the queue.
    typedef struct packed {
        logic            valid;
        logic [2:0]      rdy;
        logic [2:0][7:0] vals;
        logic [3:0]      opcode;
        logic [7:0]      offset;
        logic [3:0]      imm;
        logic [7:0]      arch;
        logic [9:0]      phys;
    } term_iq_entry_t;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int age_w(input int depth);
        return idx_w(depth) + 1;
    endfunction

endpackage

// File: rtl/term_iq_select.sv
// Issue picker: one-hot grant over ready entries plus any-ready.
// TERM_IQ_OLDEST_FIRST_EN selects oldest-first, else lowest index.
module term_iq_select
    import term_iq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]                  req_i,
`ifdef TERM_IQ_OLDEST_FIRST_EN
    input  logic [DEPTH*age_w(DEPTH)-1:0]     age_i,
`endif
    output logic [DEPTH-1:0]                  gnt_o,
    output logic                              any_o
);

`ifdef TERM_IQ_OLDEST_FIRST_EN
    localparam int AW = age_w(DEPTH);

    logic          found;
    logic [AW-1:0] best;

    // Pick the ready entry with the largest age (ties to lowest index)
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        best  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req_i[i] && (!found || age_i[i*AW +: AW] > best)) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                best     = age_i[i*AW +: AW];
                found    = 1'b1;
            end
        end
    end
`else
    logic found;

    // Pick the lowest-index ready entry
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req_i[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    assign any_o = |req_i;

endmodule

// File: rtl/terminate_issue_queue.sv
// Issue queue feeding terminate_pipeline with jump/branch micro-ops.
// Optional oldest-first select via TERM_IQ_OLDEST_FIRST_EN.
module terminate_issue_queue
    import term_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int ROB_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_opcode,
    input  logic [7:0]         in_offset,
    input  logic [3:0]         in_immediate,
    input  logic [3*TAG_W-1:0] in_src_tags,
    input  logic [2:0]         in_src_rdy,
    input  logic [23:0]        in_src_vals,
    input  logic [ROB_W-1:0]   in_rob,
    input  logic [7:0]         in_arch_dest,
    input  logic [9:0]         in_phys_dest,
    input  logic               wake_valid,
    input  logic [TAG_W-1:0]   wake_tag,
    input  logic [7:0]         wake_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_opcode,
    output logic [7:0]         out_offset,
    output logic [3:0]         out_immediate,
    output logic [15:0]        out_reg_base_val,
    output logic [7:0]         out_flag_vals,
    output logic [ROB_W-1:0]   out_rob,
    output logic [7:0]         out_arch_dest,
    output logic [9:0]         out_phys_dest
);

    term_iq_entry_t             entry_q [DEPTH];
    term_iq_entry_t             entry_d [DEPTH];
    logic [2:0][TAG_W-1:0]      tag_q   [DEPTH];
    logic [2:0][TAG_W-1:0]      tag_d   [DEPTH];
    logic [ROB_W-1:0]           rob_q   [DEPTH];
    logic [ROB_W-1:0]           rob_d   [DEPTH];

    logic [2:0][TAG_W-1:0]      in_tags;
    logic [2:0][7:0]            in_vals;
    logic [DEPTH-1:0]           alloc;
    logic                       alloc_found;
    logic [DEPTH-1:0]           rdy_vec;
    logic [DEPTH-1:0]           free_vec;
    logic [DEPTH-1:0]           sel_gnt;
    logic                       sel_any;
    logic [DEPTH-1:0]           gnt;
    logic                       enq;
    logic                       issue;
    logic                       lock_q, lock_d;
    logic [DEPTH-1:0]           lock_gnt_q, lock_gnt_d;

    assign in_tags = in_src_tags;
    assign in_vals = in_src_vals;

    // Per-entry free and fully-ready vectors
    always_comb begin
        free_vec = '0;
        rdy_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = !entry_q[i].valid;
            rdy_vec[i]  = entry_q[i].valid & (&entry_q[i].rdy);
        end
    end

    // Lowest-index free slot receives the dispatched micro-op
    always_comb begin
        alloc       = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (free_vec[i] && !alloc_found) begin
                alloc[i]    = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    assign in_ready = |free_vec;
    assign enq      = in_valid & in_ready & !flush;

`ifdef TERM_IQ_OLDEST_FIRST_EN
    localparam int AW = age_w(DEPTH);

    logic [AW-1:0]          age_q [DEPTH];
    logic [AW-1:0]          age_d [DEPTH];
    logic [DEPTH*AW-1:0]    age_flat;
    logic [AW-1:0]          iss_age;

    // Ages are dense ranks: enqueue bumps everyone, issue closes the gap
    always_comb begin
        age_flat = '0;
        iss_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_flat[i*AW +: AW] = age_q[i];
            if (gnt[i]) iss_age = iss_age | age_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            if (entry_q[i].valid) begin
                if (issue && age_q[i] > iss_age) age_d[i] = age_d[i] - 1'b1;
                if (enq) age_d[i] = age_d[i] + 1'b1;
            end
            if (enq && alloc[i]) age_d[i] = '0;
        end
    end

    // Age registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
        end
    end

    term_iq_select #(.DEPTH(DEPTH)) u_select (
        .req_i (rdy_vec),
        .age_i (age_flat),
        .gnt_o (sel_gnt),
        .any_o (sel_any)
    );
`else
    term_iq_select #(.DEPTH(DEPTH)) u_select (
        .req_i (rdy_vec),
        .gnt_o (sel_gnt),
        .any_o (sel_any)
    );
`endif

    // A stalled grant is held so a newly ready entry cannot preempt it
    always_comb begin
        gnt        = lock_q ? lock_gnt_q : sel_gnt;
        out_valid  = lock_q | sel_any;
        issue      = out_valid & out_ready;
        lock_d     = out_valid & !out_ready & !flush;
        lock_gnt_d = gnt;
    end

    // Next entry state: wakeup, issue clear, enqueue, then flush
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            tag_d[i]   = tag_q[i];
            rob_d[i]   = rob_q[i];
            for (int s = 0; s < 3; s++) begin
                if (entry_q[i].valid && !entry_q[i].rdy[s] && wake_valid
                    && tag_q[i][s] == wake_tag) begin
                    entry_d[i].rdy[s]  = 1'b1;
                    entry_d[i].vals[s] = wake_data;
                end
            end
            if (issue && gnt[i]) entry_d[i].valid = 1'b0;
            if (enq && alloc[i]) begin
                entry_d[i].valid  = 1'b1;
                entry_d[i].opcode = in_opcode;
                entry_d[i].offset = in_offset;
                entry_d[i].imm    = in_immediate;
                entry_d[i].arch   = in_arch_dest;
                entry_d[i].phys   = in_phys_dest;
                tag_d[i]          = in_tags;
                rob_d[i]          = in_rob;
                for (int s = 0; s < 3; s++) begin
                    entry_d[i].rdy[s]  = in_src_rdy[s];
                    entry_d[i].vals[s] = in_vals[s];
                    if (!in_src_rdy[s] && wake_valid && in_tags[s] == wake_tag) begin
                        entry_d[i].rdy[s]  = 1'b1;
                        entry_d[i].vals[s] = wake_data;
                    end
                end
            end
            if (flush) entry_d[i].valid = 1'b0;
        end
    end

    // Entry storage and grant lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
                tag_q[i]   <= '0;
                rob_q[i]   <= '0;
            end
            lock_q     <= 1'b0;
            lock_gnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
                tag_q[i]   <= tag_d[i];
                rob_q[i]   <= rob_d[i];
            end
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
        end
    end

    // AND-OR mux of the granted entry; all zero when nothing is granted
    always_comb begin
        out_opcode       = '0;
        out_offset       = '0;
        out_immediate    = '0;
        out_reg_base_val = '0;
        out_flag_vals    = '0;
        out_rob          = '0;
        out_arch_dest    = '0;
        out_phys_dest    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) begin
                out_opcode       |= entry_q[i].opcode;
                out_offset       |= entry_q[i].offset;
                out_immediate    |= entry_q[i].imm;
                out_reg_base_val |= {entry_q[i].vals[SRC_HI], entry_q[i].vals[SRC_LO]};
                out_flag_vals    |= entry_q[i].vals[SRC_FLAGS];
                out_rob          |= rob_q[i];
                out_arch_dest    |= entry_q[i].arch;
                out_phys_dest    |= entry_q[i].phys;
            end
        end
    end

endmodule
